// File: rtl/fir_filter_pkg.sv
// FIR filter system constants shared by the coefficient loader path.
package fir_filter_pkg;
  localparam int NTAPS      = 2;
  localparam int CLK_PERIOD = 10;
endpackage

// File: rtl/i2c_pkg.sv
// I2C bus constants and master FSM state encoding.
package i2c_pkg;
  localparam logic [6:0] I2C_ADDRESS      = 7'h50;
  localparam int         I2C_CLOCK_PERIOD = 160;

  typedef enum logic [2:0] {
    IDLE,
    START,
    BYTE,
    ACK,
    STOP,
    DONE
  } i2c_master_state_t;
endpackage

// File: rtl/i2c_sync2.sv
// Two-flop synchronizer for bus lines; resets to the idle (pulled-up) level.
module i2c_sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);
  logic meta_reg;
  logic q_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_reg <= 1'b1;
      q_reg    <= 1'b1;
    end else begin
      meta_reg <= d;
      q_reg    <= meta_reg;
    end
  end

  assign q = q_reg;
endmodule

// File: rtl/i2c_master_tx.sv
// Write-only I2C master: START, {ADDR,W}, 2*NTAPS data bytes MSB first, STOP.
// Optional slave clock stretching support is enabled by I2C_MASTER_CLOCK_STRETCH_EN.
module i2c_master_tx
  import i2c_pkg::*;
  import fir_filter_pkg::*;
#(
  parameter logic [6:0] ADDR           = I2C_ADDRESS,
  parameter int         QUARTER_CYCLES = I2C_CLOCK_PERIOD / (4 * CLK_PERIOD)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  inout  logic                  scl_inout,
  inout  logic                  sda_inout,
  input  logic                  start_in,
  input  logic [NTAPS*16-1:0]   data_in,
  output logic                  busy_out,
  output logic                  done_out,
  output logic                  nack_out
);
  localparam int W      = NTAPS * 16;
  localparam int NBYTES = 2 * NTAPS;
  localparam int BCW    = $clog2(2 * NTAPS + 2);
  localparam int QCW    = $clog2(QUARTER_CYCLES);
  localparam logic [QCW-1:0] QC_LAST   = QCW'(QUARTER_CYCLES - 1);
  localparam logic [BCW-1:0] LAST_BYTE = BCW'(NBYTES);

  i2c_master_state_t state_reg, state_next;
  logic [QCW-1:0] qcnt_reg, qcnt_next;
  logic [1:0]     quarter_reg, quarter_next;
  logic [2:0]     bit_cnt_reg, bit_cnt_next;
  logic [BCW-1:0] byte_cnt_reg, byte_cnt_next;
  logic [W-1:0]   shift_reg, shift_next;
  logic [7:0]     tx_byte_reg, tx_byte_next;
  logic           nack_reg, nack_next;

  logic sda_sync;
  logic hold;
  logic bit_end;
  logic scl_low;
  logic sda_low;

  i2c_sync2 u_sda_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (sda_inout),
    .q     (sda_sync)
  );

`ifdef I2C_MASTER_CLOCK_STRETCH_EN
  logic scl_sync;

  i2c_sync2 u_scl_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (scl_inout),
    .q     (scl_sync)
  );

  // The first two clocks of Q2 only show our own low level through the synchronizer.
  assign hold = (state_reg == BYTE || state_reg == ACK) && !scl_sync &&
                (quarter_reg == 2'd3 || (quarter_reg == 2'd2 && qcnt_reg >= QCW'(2)));
`else
  assign hold = 1'b0;
`endif

  assign bit_end = !hold && (qcnt_reg == QC_LAST) && (quarter_reg == 2'd3);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      qcnt_reg     <= '0;
      quarter_reg  <= '0;
      bit_cnt_reg  <= '0;
      byte_cnt_reg <= '0;
      shift_reg    <= '0;
      tx_byte_reg  <= '0;
      nack_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      qcnt_reg     <= qcnt_next;
      quarter_reg  <= quarter_next;
      bit_cnt_reg  <= bit_cnt_next;
      byte_cnt_reg <= byte_cnt_next;
      shift_reg    <= shift_next;
      tx_byte_reg  <= tx_byte_next;
      nack_reg     <= nack_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    qcnt_next     = qcnt_reg;
    quarter_next  = quarter_reg;
    bit_cnt_next  = bit_cnt_reg;
    byte_cnt_next = byte_cnt_reg;
    shift_next    = shift_reg;
    tx_byte_next  = tx_byte_reg;
    nack_next     = nack_reg;

    if (state_reg != IDLE && state_reg != DONE && !hold) begin
      if (qcnt_reg == QC_LAST) begin
        qcnt_next    = '0;
        quarter_next = quarter_reg + 2'd1;
      end else begin
        qcnt_next = qcnt_reg + QCW'(1);
      end
    end

    case (state_reg)
      IDLE: begin
        if (start_in) begin
          state_next    = START;
          shift_next    = data_in;
          nack_next     = 1'b0;
          qcnt_next     = '0;
          quarter_next  = '0;
          byte_cnt_next = '0;
        end
      end
      START: begin
        if (bit_end) begin
          state_next   = BYTE;
          tx_byte_next = {ADDR, 1'b0};
          bit_cnt_next = 3'd7;
        end
      end
      BYTE: begin
        if (bit_end) begin
          if (bit_cnt_reg == 3'd0) begin
            state_next = ACK;
          end else begin
            bit_cnt_next = bit_cnt_reg - 3'd1;
          end
        end
      end
      ACK: begin
        if (bit_end) begin
          if (sda_sync) begin
            nack_next  = 1'b1;
            state_next = STOP;
          end else if (byte_cnt_reg == LAST_BYTE) begin
            state_next = STOP;
          end else begin
            state_next    = BYTE;
            tx_byte_next  = shift_reg[W-1 -: 8];
            shift_next    = {shift_reg[W-9:0], 8'h00};
            bit_cnt_next  = 3'd7;
            byte_cnt_next = byte_cnt_reg + BCW'(1);
          end
        end
      end
      STOP: begin
        if (bit_end) begin
          state_next = DONE;
        end
      end
      DONE: begin
        state_next   = IDLE;
        qcnt_next    = '0;
        quarter_next = '0;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Line drive decoded from registered state only, so reset releases the bus at once.
  always_comb begin
    scl_low = 1'b0;
    sda_low = 1'b0;
    case (state_reg)
      START: begin
        sda_low = quarter_reg[1];
      end
      BYTE: begin
        scl_low = !quarter_reg[1];
        sda_low = !tx_byte_reg[bit_cnt_reg];
      end
      ACK: begin
        scl_low = !quarter_reg[1];
      end
      STOP: begin
        scl_low = (quarter_reg == 2'd0);
        sda_low = !quarter_reg[1];
      end
      default: begin
        scl_low = 1'b0;
        sda_low = 1'b0;
      end
    endcase
  end

  assign scl_inout = scl_low ? 1'b0 : 1'bz;
  assign sda_inout = sda_low ? 1'b0 : 1'bz;

  assign busy_out = (state_reg != IDLE);
  assign done_out = (state_reg == DONE);
  assign nack_out = nack_reg;
endmodule

// File: tb/tb_i2c_master_tx.sv
// Self-checking bench: i2c_master_tx against a behavioural I2C slave on a pulled-up bus.
module tb_i2c_master_tx;
  import i2c_pkg::*;
  import fir_filter_pkg::*;

  localparam int QC = 4;
  localparam int W  = NTAPS * 16;
  localparam int NB = 2 * NTAPS;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start_in = 1'b0;
  logic [W-1:0] data_in = '0;
  logic         busy_out, done_out, nack_out;

  tri1 scl_bus;
  tri1 sda_bus;
  logic slv_sda_low = 1'b0;
  logic tb_scl_low  = 1'b0;
  assign sda_bus = slv_sda_low ? 1'b0 : 1'bz;
  assign scl_bus = tb_scl_low ? 1'b0 : 1'bz;

  always #5 clk = ~clk;

  i2c_master_tx #(.ADDR(I2C_ADDRESS), .QUARTER_CYCLES(QC)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .scl_inout (scl_bus),
    .sda_inout (sda_bus),
    .start_in  (start_in),
    .data_in   (data_in),
    .busy_out  (busy_out),
    .done_out  (done_out),
    .nack_out  (nack_out)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // ---------------- behavioural slave ----------------
  logic [6:0]   slv_addr = I2C_ADDRESS;
  int           slv_nack_at = -1;
  logic         s_act = 1'b0;
  logic         s_ok = 1'b0;
  int           s_bitn = 0;
  int           s_bidx = 0;
  logic [7:0]   s_sh = '0;
  logic [W-1:0] s_word = '0;
  logic         p_scl = 1'b1;
  logic         p_sda = 1'b1;
  logic [W-1:0] rx_q[$];

  function automatic logic slv_ack(input int bidx, input logic [7:0] b);
    if (bidx == slv_nack_at) return 1'b0;
    if (bidx == 0) return (b[7:1] == slv_addr) && !b[0];
    return 1'b1;
  endfunction

  always @(posedge clk) begin
    p_scl <= scl_bus;
    p_sda <= sda_bus;
    if (scl_bus && p_scl && p_sda && !sda_bus) begin
      s_act <= 1'b1; s_ok <= 1'b1; s_bitn <= 0; s_bidx <= 0; slv_sda_low <= 1'b0;
    end else if (scl_bus && p_scl && !p_sda && sda_bus) begin
      if (s_act && s_ok && s_bidx == NB + 1) rx_q.push_back(s_word);
      s_act <= 1'b0; slv_sda_low <= 1'b0;
    end else if (s_act && scl_bus && !p_scl && s_bitn < 8) begin
      s_sh   <= {s_sh[6:0], sda_bus};
      s_bitn <= s_bitn + 1;
    end else if (s_act && !scl_bus && p_scl) begin
      if (s_bitn == 8) begin
        s_bitn <= 9;
        slv_sda_low <= slv_ack(s_bidx, s_sh);
        if (!slv_ack(s_bidx, s_sh)) begin
          s_ok <= 1'b0; s_act <= 1'b0;
        end
        if (s_bidx > 0) s_word <= {s_word[W-9:0], s_sh};
      end else if (s_bitn == 9) begin
        slv_sda_low <= 1'b0;
        s_bitn <= 0;
        s_bidx <= s_bidx + 1;
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic wait_done(output int n, output logic got);
    n = 0; got = 1'b0;
    while (n < 4000 && !got) begin
      @(posedge clk); #1;
      n++;
      if (done_out) got = 1'b1;
    end
  endtask

  // poke_at: cycle to re-pulse start_in with all-ones data; stretch_at: cycle to hold SCL low 50 clks.
  task automatic run_xfer(input logic [W-1:0] d, input logic [6:0] sa, input int na,
                          input logic exp_nack, input int exp_lat, input logic exp_valid,
                          input int poke_at, input int stretch_at, input string tag);
    int n; logic got;
    slv_addr = sa; slv_nack_at = na; rx_q.delete();
    @(negedge clk); data_in = d; start_in = 1'b1;
    @(posedge clk); #1; start_in = 1'b0;
    chk({tag, "_busy_accept"}, longint'(busy_out), 1);
    n = 0; got = 1'b0;
    while (n < 4000 && !got) begin
      @(posedge clk); #1;
      n++;
      if (n == poke_at) begin start_in = 1'b1; data_in = '1; end
      if (n == poke_at + 1) start_in = 1'b0;
      if (n == stretch_at) tb_scl_low = 1'b1;
      if (n == stretch_at + 50) tb_scl_low = 1'b0;
      if (done_out) got = 1'b1;
    end
    chk({tag, "_done_seen"}, longint'(got), 1);
    if (exp_lat >= 0) chk({tag, "_latency"}, longint'(n), longint'(exp_lat));
    else chk({tag, "_stretch_latency_window"}, longint'(n >= 752 + 30 && n <= 752 + 55), 1);
    chk({tag, "_nack"}, longint'(nack_out), longint'(exp_nack));
    chk({tag, "_busy_in_done"}, longint'(busy_out), 1);
    @(posedge clk); #1;
    chk({tag, "_busy_after"}, longint'(busy_out), 0);
    chk({tag, "_done_pulse"}, longint'(done_out), 0);
    chk({tag, "_rx_count"}, longint'(rx_q.size()), longint'(exp_valid));
    if (exp_valid && rx_q.size() > 0) chk({tag, "_rx_word"}, longint'(rx_q[0]), longint'(d));
    repeat (3) @(posedge clk);
  endtask

  typedef struct {
    logic [W-1:0] data;
    logic [6:0]   sa;
    int           nack_at;
    logic         exp_nack;
    int           exp_lat;
    logic         exp_valid;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int n; logic got; int na; int bytes;
    logic [W-1:0] w1, w2, d;

    vecs[0] = '{32'h1234_ABCD, I2C_ADDRESS,         -1, 1'b0, 752, 1'b1};
    vecs[1] = '{32'hDEAD_BEEF, I2C_ADDRESS ^ 7'h01, -1, 1'b1, 176, 1'b0};
    vecs[2] = '{32'h0000_0000, I2C_ADDRESS,          1, 1'b1, 320, 1'b0};
    vecs[3] = '{32'hFFFF_FFFF, I2C_ADDRESS,          3, 1'b1, 608, 1'b0};
    vecs[4] = '{32'h8001_7FFE, I2C_ADDRESS,          4, 1'b1, 752, 1'b0};
    vecs[5] = '{32'h5A5A_A5A5, I2C_ADDRESS,         -1, 1'b0, 752, 1'b1};

    // reset state
    repeat (3) @(posedge clk); #1;
    chk("rst_busy", longint'(busy_out), 0);
    chk("rst_done", longint'(done_out), 0);
    chk("rst_nack", longint'(nack_out), 0);
    chk("rst_scl", longint'(scl_bus), 1);
    chk("rst_sda", longint'(sda_bus), 1);
    @(negedge clk); rst_n = 1'b1;
    repeat (4) @(posedge clk);

    for (int i = 0; i < 6; i++) begin
      run_xfer(vecs[i].data, vecs[i].sa, vecs[i].nack_at, vecs[i].exp_nack,
               vecs[i].exp_lat, vecs[i].exp_valid, -10, -100, $sformatf("vec%0d", i));
      $display("vec %0d data=%08h nack_at=%0d done", i, vecs[i].data, vecs[i].nack_at);
    end

    // randomized transfers against the frame-length model
    for (int i = 0; i < 8; i++) begin
      d  = W'($urandom);
      na = int'($urandom_range(0, NB + 3));
      if (na > NB) na = -1;
      bytes = (na >= 0) ? na + 1 : NB + 1;
      run_xfer(d, I2C_ADDRESS, na, na >= 0, (8 + 36 * bytes) * QC, na < 0, -10, -100,
               $sformatf("rnd%0d", i));
      $display("rnd %0d data=%08h nack_at=%0d done", i, d, na);
    end

    // start_in while busy must be ignored
    run_xfer(32'h1234_ABCD, I2C_ADDRESS, -1, 1'b0, 752, 1'b1, 100, -100, "busy_poke");
    $display("busy_poke done");

    // reset in the middle of data byte 1
    slv_addr = I2C_ADDRESS; slv_nack_at = -1;
    @(negedge clk); data_in = 32'hA5A5_5A5A; start_in = 1'b1;
    @(posedge clk); #1; start_in = 1'b0;
    repeat (200) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_scl", longint'(scl_bus), 1);
    chk("midrst_sda", longint'(sda_bus), 1);
    chk("midrst_busy", longint'(busy_out), 0);
    chk("midrst_done", longint'(done_out), 0);
    chk("midrst_nack", longint'(nack_out), 0);
    repeat (3) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    repeat (4) @(posedge clk);
    run_xfer(32'h0000_0001, I2C_ADDRESS, -1, 1'b0, 752, 1'b1, -10, -100, "after_rst");
    $display("mid-frame reset sequence done");

    // back-to-back with start_in held high
    w1 = 32'hCAFE_F00D; w2 = 32'h0F1E_2D3C;
    slv_addr = I2C_ADDRESS; slv_nack_at = -1; rx_q.delete();
    @(negedge clk); data_in = w1; start_in = 1'b1;
    @(posedge clk); #1; data_in = w2;
    wait_done(n, got);
    chk("b2b_first_lat", longint'(n), 752);
    @(posedge clk); #1;
    chk("b2b_idle_gap", longint'(busy_out), 0);
    @(posedge clk); #1;
    chk("b2b_second_accept", longint'(busy_out), 1);
    start_in = 1'b0;
    wait_done(n, got);
    chk("b2b_second_lat", longint'(n), 752);
    repeat (3) @(posedge clk);
    chk("b2b_rx_count", longint'(rx_q.size()), 2);
    if (rx_q.size() == 2) begin
      chk("b2b_word0", longint'(rx_q[0]), longint'(w1));
      chk("b2b_word1", longint'(rx_q[1]), longint'(w2));
    end
    $display("back-to-back sequence done");

`ifdef I2C_MASTER_CLOCK_STRETCH_EN
    // stretch SCL inside byte index 2 (second data byte), fifth bit
    run_xfer(32'h1357_9BDF, I2C_ADDRESS, -1, 1'b0, -1, 1'b1, -10, 369, "stretch");
    $display("stretch sequence done");
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
